// File: rtl/mux_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared constants and helpers for the N:1 stream selector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam int MUX_MODE_RR    = 0;
    localparam int MUX_MODE_FIXED = 1;

    // Channel-index width; never narrower than one bit.
    function automatic int mux_ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin / fixed-priority one-hot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MUX_MODE_RR,
    localparam int CH_W = mux_ch_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_grant
);

    int start;
    int idx;

    // Search starts at ptr and wraps modulo N, so non-power-of-two N works.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        start     = (MODE == MUX_MODE_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_n_to_1_stream.sv
// ============================================================================
// Module  : mux_n_to_1_stream
// Brief   : N-input valid/ready stream selector with arbitration and a
//           registered output stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_to_1_stream
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MUX_MODE_RR,
    localparam int CH_W = mux_ch_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CH_W-1:0]      out_ch,
    input  logic                 out_ready
);

    logic              load;
    logic [N-1:0]      req;
    logic [N-1:0]      grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_grant;
    logic [WIDTH-1:0]  mux_data;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [CH_W-1:0]   ptr_q,       ptr_d;

    assign load = !out_valid_q || out_ready;
    assign req  = in_valid & {N{load}};

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // No handshake may complete while reset is held.
    assign in_ready = rst_n ? grant : '0;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (any_grant) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_ch_d    = grant_idx;
            if (MODE == MUX_MODE_RR) begin
                ptr_d = (grant_idx == CH_W'(N-1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_to_1_stream.sv
// ============================================================================
// Module  : tb_mux_n_to_1_stream
// Brief   : Directed self-checking bench: RR N=4, fixed priority N=4, RR N=3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_n_to_1_stream;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Round-robin, N=4
    logic [3:0]  a_in_valid;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_ch;
    logic        a_out_ready;

    // Fixed priority, N=4
    logic [3:0]  b_in_valid;
    logic [31:0] b_in_data;
    logic [3:0]  b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_ready;

    // Round-robin, N=3
    logic [2:0]  c_in_valid;
    logic [23:0] c_in_data;
    logic [2:0]  c_in_ready;
    logic        c_out_valid;
    logic [7:0]  c_out_data;
    logic [1:0]  c_out_ch;
    logic        c_out_ready;

    mux_n_to_1_stream #(.N(4), .WIDTH(8), .MODE(0)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
        .out_ready(a_out_ready)
    );

    mux_n_to_1_stream #(.N(4), .WIDTH(8), .MODE(1)) u_dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
        .out_ready(b_out_ready)
    );

    mux_n_to_1_stream #(.N(3), .WIDTH(8), .MODE(0)) u_dut_n3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_ch(c_out_ch),
        .out_ready(c_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        a_in_valid  = 4'b1111;
        a_in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        a_out_ready = 1'b1;
        b_in_valid  = 4'b0000;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        c_in_valid  = 3'b000;
        c_in_data   = '0;
        c_out_ready = 1'b1;
        #3;
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid);
        end
        n_cmp++;
        if (a_out_data !== 8'h00 || a_out_ch !== 2'd0) begin
            n_err++; $display("FAIL reset_out_data_ch: got %h/%0d expected 00/0", a_out_data, a_out_ch);
        end
        n_cmp++;
        if (a_in_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 0000", a_in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 4'b0001) begin
            n_err++; $display("FAIL reset_first_grant: got %b expected 0001", a_in_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch;
        for (int k = 0; k < 8; k++) begin
            exp_ch = 2'(k % 4);
            n_cmp++;
            if (a_in_ready !== (4'b0001 << exp_ch)) begin
                n_err++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, a_in_ready, 4'b0001 << exp_ch);
            end
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_out_ch !== exp_ch ||
                a_out_data !== (8'h10 + 8'h11 * 8'(exp_ch))) begin
                n_err++;
                $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         k, a_out_valid, a_out_ch, a_out_data, exp_ch, 8'h10 + 8'h11 * 8'(exp_ch));
            end
        end
    endtask

    task automatic test_midstream_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_out: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                     a_out_valid, a_out_data, a_out_ch);
        end
        n_cmp++;
        if (a_in_ready !== 4'b0000) begin
            n_err++; $display("FAIL midreset_in_ready: got %b expected 0000", a_in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 4'b0001) begin
            n_err++; $display("FAIL midreset_ptr: got %b expected 0001", a_in_ready);
        end
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_ch !== 2'd0 || a_out_data !== 8'h10) begin
            n_err++;
            $display("FAIL midreset_first_word: got v=%b ch=%0d d=%h expected v=1 ch=0 d=10",
                     a_out_valid, a_out_ch, a_out_data);
        end
    endtask

    task automatic test_backpressure();
        a_in_valid         = 4'b0100;
        a_in_data[23:16]   = 8'hA5;
        a_out_ready        = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 4'b0100) begin
            n_err++; $display("FAIL bp_load_ready: got %b expected 0100", a_in_ready);
        end
        tick();
        a_in_data[23:16] = 8'h5A;
        a_out_ready      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (a_in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, a_in_ready);
            end
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5 || a_out_ch !== 2'd2) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
                         k, a_out_valid, a_out_data, a_out_ch);
            end
        end
        a_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 4'b0100) begin
            n_err++; $display("FAIL bp_release_ready: got %b expected 0100", a_in_ready);
        end
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'h5A || a_out_ch !== 2'd2) begin
            n_err++;
            $display("FAIL bp_next_word: got v=%b d=%h ch=%0d expected v=1 d=5a ch=2",
                     a_out_valid, a_out_data, a_out_ch);
        end
    endtask

    task automatic test_idle_drain();
        a_in_valid = 4'b0000;
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_empty: got %b expected 0", a_out_valid);
        end
        a_in_valid       = 4'b0010;
        a_in_data[15:8]  = 8'h77;
        tick();
        a_in_valid = 4'b0000;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'h77 || a_out_ch !== 2'd1) begin
            n_err++;
            $display("FAIL drain_word: got v=%b d=%h ch=%0d expected v=1 d=77 ch=1",
                     a_out_valid, a_out_data, a_out_ch);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b0 || a_out_data !== 8'h77 || a_out_ch !== 2'd1) begin
                n_err++;
                $display("FAIL drain_after[%0d]: got v=%b d=%h ch=%0d expected v=0 d=77 ch=1",
                         k, a_out_valid, a_out_data, a_out_ch);
            end
        end
    endtask

    task automatic test_fixed_priority();
        b_in_valid = 4'b1010;
        b_in_data  = {8'hD3, 8'h00, 8'hB1, 8'h00};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (b_in_ready !== 4'b0010) begin
                n_err++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", k, b_in_ready);
            end
            tick();
            n_cmp++;
            if (b_out_ch !== 2'd1 || b_out_data !== 8'hB1) begin
                n_err++; $display("FAIL fixed_out[%0d]: got ch=%0d d=%h expected ch=1 d=b1", k, b_out_ch, b_out_data);
            end
        end
        b_in_valid = 4'b1000;
        #1;
        n_cmp++;
        if (b_in_ready !== 4'b1000) begin
            n_err++; $display("FAIL fixed_ready_ch3: got %b expected 1000", b_in_ready);
        end
        tick();
        n_cmp++;
        if (b_out_ch !== 2'd3 || b_out_data !== 8'hD3) begin
            n_err++; $display("FAIL fixed_out_ch3: got ch=%0d d=%h expected ch=3 d=d3", b_out_ch, b_out_data);
        end
        b_in_valid = 4'b0000;
    endtask

    task automatic test_wrap_n3();
        c_in_data  = {8'hC2, 8'hC1, 8'hC0};
        c_in_valid = 3'b010;
        tick();
        n_cmp++;
        if (c_out_ch !== 2'd1 || c_out_data !== 8'hC1) begin
            n_err++; $display("FAIL wrap_setup: got ch=%0d d=%h expected ch=1 d=c1", c_out_ch, c_out_data);
        end
        c_in_valid = 3'b101;
        #1;
        n_cmp++;
        if (c_in_ready !== 3'b100) begin
            n_err++; $display("FAIL wrap_ptr2_ready: got %b expected 100", c_in_ready);
        end
        tick();
        n_cmp++;
        if (c_out_ch !== 2'd2 || c_out_data !== 8'hC2) begin
            n_err++; $display("FAIL wrap_grant2: got ch=%0d d=%h expected ch=2 d=c2", c_out_ch, c_out_data);
        end
        n_cmp++;
        if (c_in_ready !== 3'b001) begin
            n_err++; $display("FAIL wrap_ptr0_ready: got %b expected 001", c_in_ready);
        end
        tick();
        n_cmp++;
        if (c_out_ch !== 2'd0 || c_out_data !== 8'hC0) begin
            n_err++; $display("FAIL wrap_grant0: got ch=%0d d=%h expected ch=0 d=c0", c_out_ch, c_out_data);
        end
        n_cmp++;
        if (c_in_ready !== 3'b100) begin
            n_err++; $display("FAIL wrap_ptr1_ready: got %b expected 100", c_in_ready);
        end
        c_in_valid = 3'b000;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_round_robin();
        test_midstream_reset();
        test_backpressure();
        test_idle_drain();
        test_fixed_priority();
        test_wrap_n3();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_n_to_1_stream.md
# mux_n_to_1_stream

Parametrised N-input, WIDTH-bit selector with per-channel valid/ready handshakes, built-in arbitration and a registered output stage. Generalises the 1-bit 2:1 selector: the select is produced internally by a round-robin or fixed-priority arbiter, and each transfer is held in an output register until the consumer accepts it. It sits between several producer streams and one shared consumer, such as a shared bus or a shared output port.

## Interface
- `N`, default 4: number of input channels, N ≥ 2.
- `WIDTH`, default 8: data width per channel, WIDTH ≥ 1.
- `MODE`, default 0: arbitration mode. 0 = round-robin, 1 = fixed priority (lowest index wins).
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `in_valid  in  N`: bit i means channel i offers data.
- `in_data  in  N*WIDTH`: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready  out  N`: bit i means channel i's data is taken this cycle. One-hot or zero.
- `out_valid  out  1`: output register holds a word.
- `out_data  out  WIDTH`: registered data.
- `out_ch  out  CH_W`: index of the source channel of `out_data`. CH_W = $clog2(N).
- `out_ready  in  1`: consumer accepts the word.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Request vector: `in_valid` masked by `load`. Exactly one requesting channel is granted per cycle. `in_ready = grant` (combinational).
- On a clock edge where a grant exists:
  - `out_data` ← granted channel's data.
  - `out_ch` ← its index.
  - `out_valid` ← 1.
- On a clock edge where `out_ready && out_valid` and there is no grant: `out_valid` ← 0. `out_data` and `out_ch` hold their values.
- A transfer occurs on either side only when valid && ready are both high at a rising edge.
- MODE 0, round-robin:
  - A pointer `ptr` (CH_W bits) marks the highest-priority channel.
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N; N need not be a power of two).
  - After a grant to channel g, `ptr` ← (g+1) mod N.
  - With no grant, `ptr` holds.
- MODE 1, fixed priority: lowest-index requesting channel wins. `ptr` is unused.
- Producers must hold `in_valid` and `in_data` stable until accepted. The block does not check this.
- Reset, while `rst_n` = 0, asynchronous:
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0.
  - `in_ready` forced to all zeros.
  - Reset asserted mid-transfer discards any held word. No handshake completes in that cycle.

## Timing
- Latency: 1 cycle from input handshake to `out_valid` high.
- Throughput: one word per cycle when `out_ready` is held high (simultaneous drain and load allowed).
- Backpressure:
  - With `out_valid` = 1 and `out_ready` = 0, all `in_ready` = 0.
  - `out_data` and `out_ch` stay stable until accepted.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from `in_data` to any output.
- Only one channel requesting: it is granted every cycle the output can load, in both modes.
- No channel requesting while the output drains: `out_valid` falls on the next edge.
- Round-robin fairness: a continuously requesting channel waits at most N-1 grants.

## Structure
- Shared package `mux_pkg`: constants `MUX_MODE_RR = 0` and `MUX_MODE_FIXED = 1`, plus a helper function for CH_W.
- One sub-module, `rr_arbiter`:
  - Parameters N, MODE. Inputs: `req[N]`, `ptr`. Outputs: one-hot `grant[N]`, `grant_idx[CH_W]`, `any_grant`.
  - Purely combinational.
- The top level holds `ptr`, the output register and the data multiplexer (AND-OR over one-hot grant).

## Test plan
- Reset: assert `rst_n` = 0 mid-stream with `out_valid` = 1 → `out_valid`, `out_data`, `out_ch` = 0 and `in_ready` = 0000 immediately. After release, the first grant goes to channel 0.
- Round-robin, N=4, WIDTH=8, all four channels valid continuously with data 0x10/0x21/0x32/0x43, `out_ready` = 1 → `out_ch` sequence 0,1,2,3,0,1…, one word per cycle, first `out_valid` one cycle after the first handshake.
- Fixed priority, MODE=1, channels 1 and 3 valid, `out_ready` = 1 → only channel 1 is granted until it drops `in_valid`, then channel 3.
- Backpressure: `out_ready` = 0 for 5 cycles while channel 2 holds 0xA5 → `out_data` = 0xA5 and `out_ch` = 2 stable, `in_ready` = 0000. Then `out_ready` = 1 → next word loads the same cycle.
- Wrap with N=3 (non-power-of-two): ptr=2 and channels 0 and 2 request → grant 2, then ptr=0 and channel 0 is granted next.
- Idle drain: a single word from channel 1, then no valids, `out_ready` = 1 → `out_valid` high for exactly 1 cycle. `out_data` and `out_ch` retain their last value afterwards.
